// File: rtl/imgproc_cfg_ctrl_pkg.sv
// Shared types and default constants for the image-processor configuration controller.
package imgproc_cfg_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_HOLD = 2'd2
  } cfg_state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int DEFAULT_MIN_FRAMES      = 2;

  // Width of a down/up counter that must hold values 0..max_val (never narrower than 1 bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/imgproc_cfg_ctrl_key_debounce.sv
// One push-button path: 2-flop synchroniser, stability counter and press-pulse generator.
module key_debounce
  import imgproc_cfg_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // The count only survives while the synchronised input disagrees with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q >= CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = level_q & ~level_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/imgproc_cfg_ctrl.sv
// Collects debounced key presses into a shadow mode/filter setting and commits it on frame
// boundaries, enforcing a minimum number of frames between two committed changes.
module imgproc_cfg_ctrl
  import imgproc_cfg_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int MIN_FRAMES      = DEFAULT_MIN_FRAMES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] key_n,
  input  logic       frame_start,
  output logic       mode_out,
  output logic       filter_out,
  output logic       pending,
  output logic [9:0] led
);

  localparam int            HW        = cnt_width(MIN_FRAMES);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(MIN_FRAMES);

  logic [1:0] press;

  for (genvar i = 0; i < 2; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .key_n  (key_n[i]),
      .press  (press[i])
    );
  end

  // Bit 0 of shadow/cfg is mode, bit 1 is filter.
  cfg_state_e    state_q, state_d;
  logic [1:0]    shadow_q, shadow_d;
  logic [1:0]    cfg_q, cfg_d;
  logic [HW-1:0] holdoff_q, holdoff_d;
  logic          pend_flag_q, pend_flag_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          any_press;

  assign any_press = (press != 2'b00);

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    holdoff_d   = holdoff_q;
    pend_flag_d = pend_flag_q;
    shadow_d    = shadow_q ^ press;
    frame_cnt_d = frame_cnt_q;
    if (frame_start) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (any_press) begin
          state_d = ST_PEND;
        end
      end
      // Commit uses the pre-pulse shadow; a coincident press is remembered for the next round.
      ST_PEND: begin
        if (frame_start) begin
          cfg_d       = shadow_q;
          holdoff_d   = HOLD_LOAD;
          pend_flag_d = any_press;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (any_press) begin
          pend_flag_d = 1'b1;
        end
        if (holdoff_q == '0) begin
          state_d     = (pend_flag_q || any_press) ? ST_PEND : ST_IDLE;
          pend_flag_d = 1'b0;
        end else if (frame_start) begin
          holdoff_d = holdoff_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      shadow_q    <= 2'b00;
      cfg_q       <= 2'b00;
      holdoff_q   <= '0;
      pend_flag_q <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      cfg_q       <= cfg_d;
      holdoff_q   <= holdoff_d;
      pend_flag_q <= pend_flag_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign mode_out   = cfg_q[0];
  assign filter_out = cfg_q[1];
  assign pending    = (state_q == ST_PEND) || pend_flag_q;
  assign led        = {cfg_q[1], cfg_q[0], frame_cnt_q};

endmodule

// File: tb/tb_imgproc_cfg_ctrl.sv
// Randomised and directed bench for imgproc_cfg_ctrl against a behavioural reference model.
module tb_imgproc_cfg_ctrl;

  localparam int DB = 4;
  localparam int MF = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] key_n;
  logic       frame_start;
  logic       mode_out;
  logic       filter_out;
  logic       pending;
  logic [9:0] led;

  always #5 clk = ~clk;

  imgproc_cfg_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .MIN_FRAMES     (MF)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_n      (key_n),
    .frame_start(frame_start),
    .mode_out   (mode_out),
    .filter_out (filter_out),
    .pending    (pending),
    .led        (led)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: key history window per key, plus the commit/hold bookkeeping.
  logic [1:0]    m_hist [2];
  logic [DB-1:0] m_win  [2];
  logic [1:0]    m_level;
  logic [1:0]    m_press;
  logic [1:0]    m_shadow;
  logic [1:0]    m_cfg;
  bit            m_armed;
  bit            m_holding;
  bit            m_later;
  int            m_hold_left;
  int            m_frames;

  function automatic void model_reset();
    m_hist[0]   = 2'b11;
    m_hist[1]   = 2'b11;
    m_win[0]    = '1;
    m_win[1]    = '1;
    m_level     = 2'b11;
    m_press     = 2'b00;
    m_shadow    = 2'b00;
    m_cfg       = 2'b00;
    m_armed     = 1'b0;
    m_holding   = 1'b0;
    m_later     = 1'b0;
    m_hold_left = 0;
    m_frames    = 0;
  endfunction

  function automatic void model_edge(input logic [1:0] k, input logic fs);
    logic [1:0] s;
    logic [1:0] new_level;
    logic [1:0] new_press;
    logic [1:0] p;
    bit         any;
    s         = m_hist[0];
    m_hist[0] = m_hist[1];
    m_hist[1] = k;
    p         = m_press;
    any       = (p != 2'b00);
    for (int i = 0; i < 2; i++) begin
      m_win[i]     = {m_win[i][DB-2:0], s[i]};
      new_level[i] = m_level[i];
      if (m_win[i] == {DB{~m_level[i]}}) new_level[i] = ~m_level[i];
      new_press[i] = m_level[i] & ~new_level[i];
    end
    if (m_armed) begin
      if (fs) begin
        m_cfg       = m_shadow;
        m_armed     = 1'b0;
        m_holding   = 1'b1;
        m_hold_left = MF;
        m_later     = any;
      end
    end else if (m_holding) begin
      if (m_hold_left == 0) begin
        m_armed   = m_later || any;
        m_holding = 1'b0;
        m_later   = 1'b0;
      end else begin
        if (any) m_later = 1'b1;
        if (fs) m_hold_left = m_hold_left - 1;
      end
    end else if (any) begin
      m_armed = 1'b1;
    end
    m_shadow = m_shadow ^ p;
    if (fs) m_frames = (m_frames + 1) % 256;
    m_level = new_level;
    m_press = new_press;
  endfunction

  function automatic logic [12:0] exp_outs();
    logic [7:0] f;
    f = m_frames[7:0];
    return {(m_armed || m_later), m_cfg[1], m_cfg[0], m_cfg[1], m_cfg[0], f};
  endfunction

  function automatic logic [12:0] dut_outs();
    return {pending, filter_out, mode_out, led};
  endfunction

  // Called at a falling edge; drives inputs for one cycle and compares after the next rising edge.
  task automatic applyStimulus(input logic [1:0] k, input logic fs);
    key_n       = k;
    frame_start = fs;
    @(posedge clk);
    model_edge(k, fs);
    @(negedge clk);
    checkOutput("cycle", 32'(dut_outs()), 32'(exp_outs()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(2'b11, 1'b0);
  endtask

  task automatic frame();
    applyStimulus(2'b11, 1'b1);
  endtask

  task automatic press_key(input logic [1:0] mask);
    for (int i = 0; i < 8; i++) applyStimulus(~mask, 1'b0);
    idle(8);
  endtask

  task automatic do_reset();
    key_n       = 2'b11;
    frame_start = 1'b0;
    #2 reset_n  = 1'b0;
    #1 checkOutput("async_rst", 32'(dut_outs()), 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [1:0] kv;
    reset_n     = 1'b0;
    key_n       = 2'b11;
    frame_start = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checkOutput("reset", 32'(dut_outs()), 32'h0);
    reset_n = 1'b1;

    // Single mode press, commit on the next frame.
    for (int i = 0; i < 10; i++) applyStimulus(2'b10, 1'b0);
    idle(8);
    checkOutput("press_pending", 32'(pending), 32'd1);
    frame();
    checkOutput("commit_mode", 32'(mode_out), 32'd1);
    checkOutput("commit_pend", 32'(pending), 32'd0);
    frame();
    frame();
    idle(2);
    checkOutput("back_idle", 32'(pending), 32'd0);

    // Bouncy key: runs shorter than the debounce window never register.
    for (int i = 0; i < 30; i++) applyStimulus((((i / 3) % 2) != 0) ? 2'b10 : 2'b11, 1'b0);
    idle(8);
    checkOutput("glitch_nopend", 32'(pending), 32'd0);

    // Two presses cancel, yet the commit still enters hold.
    do_reset();
    press_key(2'b01);
    press_key(2'b01);
    checkOutput("cancel_pend", 32'(pending), 32'd1);
    frame();
    checkOutput("cancel_mode", 32'(mode_out), 32'd0);
    checkOutput("cancel_hold", 32'(pending), 32'd0);

    // Filter press during hold waits out the minimum frame spacing.
    press_key(2'b10);
    checkOutput("hold_flag", 32'(pending), 32'd1);
    frame();
    checkOutput("hold_f1", 32'(filter_out), 32'd0);
    frame();
    checkOutput("hold_f2", 32'(filter_out), 32'd0);
    idle(2);
    frame();
    checkOutput("hold_commit", 32'(filter_out), 32'd1);

    // Frame counter wrap.
    do_reset();
    for (int i = 0; i < 257; i++) begin
      frame();
      idle(1);
    end
    checkOutput("frame_wrap", 32'(led[7:0]), 32'd1);

    // Reset while a change is pending.
    do_reset();
    press_key(2'b01);
    frame();
    frame();
    frame();
    idle(2);
    press_key(2'b01);
    checkOutput("pend_before_rst", 32'({pending, mode_out}), 32'b11);
    do_reset();
    idle(2);
    checkOutput("pend_after_rst", 32'(pending), 32'd0);

    // Randomised keys with bounce and random frame pulses.
    kv = 2'b11;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) begin
        do_reset();
        kv = 2'b11;
      end
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 5) == 0) kv[k] = ~kv[k];
      end
      applyStimulus(kv, ($urandom_range(0, 6) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/imgproc_cfg_ctrl.md
IMGPROC_CFG_CTRL -- requirements
Module: imgproc_cfg_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL set the clk cycles a key level must hold stable to be accepted (20 ms at 50 MHz).
REQ-002 Parameter MIN_FRAMES, default 2, SHALL set the minimum frame_start pulses between two committed configuration changes.
REQ-003 Port clk  input  1  SHALL be the single system clock, 50 MHz.
REQ-004 Port reset_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 Port key_n  input  2  SHALL carry the raw, asynchronous, active-low push-buttons: bit0 = mode, bit1 = filter.
REQ-006 Port frame_start  input  1  SHALL be a one-cycle pulse, in the clk domain, marking the start of each video frame.
REQ-007 Port mode_out  output  1  SHALL drive the image-processor mode conduit.
REQ-008 Port filter_out  output  1  SHALL drive the image-processor filter conduit.
REQ-009 Port pending  output  1  SHALL be high while an accepted change is not yet committed.
REQ-010 Port led  output  10  SHALL drive status: led[9]=filter_out, led[8]=mode_out, led[7:0]=frame count.

Function
REQ-011 Each key_n bit SHALL pass through a 2-flop synchroniser, then a per-key debounce counter.
REQ-012 A debounced level SHALL update only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce SHALL restart the count.
REQ-013 A press event SHALL be a one-cycle pulse on a debounced 1->0 transition; a release SHALL generate no event.
REQ-014 A press event on key 0 SHALL toggle shadow_mode; a press on key 1 SHALL toggle shadow_filter; simultaneous presses SHALL toggle both.
REQ-015 FSM states SHALL be IDLE, PEND, HOLD.
REQ-016 IDLE: a press event SHALL move to PEND on the next cycle.
REQ-017 PEND: on frame_start, the outputs SHALL load the shadow values registered before that cycle, visible one cycle after the pulse; holdoff SHALL load MIN_FRAMES; the FSM SHALL go to HOLD.
REQ-018 Presses in PEND SHALL re-toggle the shadow; two presses of one key SHALL cancel, and a commit with shadow equal to the outputs SHALL still go to HOLD.
REQ-019 A press coinciding with the committing frame_start SHALL update the shadow after the commit and set pend_flag.
REQ-020 HOLD: presses SHALL update the shadow and set pend_flag; each frame_start SHALL decrement holdoff; at holdoff==0 the FSM SHALL go to PEND (pend_flag set, then cleared) or IDLE.
REQ-021 With MIN_FRAMES=0, HOLD SHALL exit on the cycle after entry.
REQ-022 pending SHALL equal (state==PEND) OR pend_flag.
REQ-023 The frame counter SHALL increment on every frame_start in every state and wrap 255->0.

Reset
REQ-024 Asserting reset_n low, including mid-debounce or in PEND/HOLD, SHALL immediately clear mode_out, filter_out, pending, led, shadow, pend_flag, holdoff, the frame counter and the debounce counters, and set the FSM to IDLE.
REQ-025 After reset, synchroniser and debounced levels SHALL be 1 (released), so a key held through reset generates no press event.

Structure
REQ-026 A shared package SHALL hold the FSM state enum and the default constants for DEBOUNCE_CYCLES and MIN_FRAMES.
REQ-027 One sub-module, key_debounce (synchroniser, debounce counter, press-pulse generator), SHALL be instantiated once per key.

Verification (DEBOUNCE_CYCLES=4, MIN_FRAMES=2)
REQ-028 Hold key_n[0] low 10 cycles, then pulse frame_start -> pending=1 after the debounce; mode_out=1 one cycle after frame_start; pending=0.
REQ-029 Toggle key_n[0] with 3-cycle glitches for 30 cycles -> no press event; state stays IDLE.
REQ-030 Press key0 twice before frame_start -> commit with mode_out=0; FSM enters HOLD; pending drops.
REQ-031 Press key1 in HOLD, then 2 frame_start pulses -> filter_out stays 0 through HOLD; commits to 1 on the third frame_start.
REQ-032 Issue 257 frame_start pulses -> led[7:0]=1.
REQ-033 Assert reset_n low while in PEND with mode_out=1 -> all outputs 0 the same cycle; state IDLE after release.
